// File: rtl/dmem_if.sv
// Load/store handshake bundle between the core's MEM stage (master) and the data memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory slave: one request at a time, response WAIT_CYCLES+1 edges after accept, held until rsp_ready.
// DMEM_MISALIGN_ERR_EN: when defined, any access with req_addr[1:0]!=0 returns rsp_err instead of using the aligned word.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept, commit;

    logic        cap_we;
    logic [29:0] cap_word;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic          in_range;
    logic          misalign;
    logic          err;

    assign widx     = cap_word[AW-1:0];
    assign in_range = ({2'b00, cap_word} < 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_ERR_EN
    logic [1:0] cap_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cap_lo <= 2'b00;
        else if (accept)
            cap_lo <= bus.req_addr[1:0];
    end

    assign misalign = |cap_lo;
`else
    logic unused_addr_lo;

    assign unused_addr_lo = ^bus.req_addr[1:0];
    assign misalign       = 1'b0;
`endif

    assign err = !in_range || misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // The counter is loaded on accept and the commit happens one edge after it reaches zero,
    // giving the WAIT_CYCLES+1 edge accept-to-response latency.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 4'd0;
            cap_we      <= 1'b0;
            cap_word    <= 30'd0;
            cap_wdata   <= 32'd0;
            cap_wstrb   <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= 4'(WAIT_CYCLES);
                cap_we    <= bus.req_we;
                cap_word  <= bus.req_addr[31:2];
                cap_wdata <= bus.req_wdata;
                cap_wstrb <= bus.req_wstrb;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err;
                rsp_rdata_q <= (!cap_we && !err) ? mem[widx] : 32'd0;
            end else if (state == ST_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= 32'd0;
            end
        end
    end

    // Storage is never reset; the rst gate keeps an aborted store from landing on a coincident edge.
    always_ff @(posedge clk) begin
        if (commit && cap_we && !err && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_wstrb[i])
                    mem[widx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vectors against two responders: default timing (WAIT_CYCLES=2) and zero wait states.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_if ia();
    dmem_if ib();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    // Shared request fields; sel picks which responder sees valid/ready and whose outputs are observed.
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;

    assign ia.req_valid = req_valid && !sel;
    assign ib.req_valid = req_valid && sel;
    assign ia.rsp_ready = rsp_ready && !sel;
    assign ib.rsp_ready = rsp_ready && sel;
    assign ia.req_we    = req_we;
    assign ib.req_we    = req_we;
    assign ia.req_addr  = req_addr;
    assign ib.req_addr  = req_addr;
    assign ia.req_wdata = req_wdata;
    assign ib.req_wdata = req_wdata;
    assign ia.req_wstrb = req_wstrb;
    assign ib.req_wstrb = req_wstrb;

    wire        m_req_ready = sel ? ib.req_ready : ia.req_ready;
    wire        m_rsp_valid = sel ? ib.rsp_valid : ia.rsp_valid;
    wire [31:0] m_rsp_rdata = sel ? ib.rsp_rdata : ia.rsp_rdata;
    wire        m_rsp_err   = sel ? ib.rsp_err   : ia.rsp_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Accept on the next edge, then wait (bounded) for rsp_valid; lat counts edges after the accept edge.
    task automatic start_req(input logic s, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb, output int lat);
        sel       = s;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h0BAD_0BAD;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (m_rsp_valid) break;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        logic [31:0] held;

        // Default build ignores addr[1:0]; with the misalignment check both accesses below are errors.
`ifdef DMEM_MISALIGN_ERR_EN
        localparam logic [31:0] MIS_LD_DATA = 32'h0;
        localparam logic        MIS_ERR     = 1'b1;
        localparam logic [31:0] W4_AFTER    = 32'hDEADBEEF;
`else
        localparam logic [31:0] MIS_LD_DATA = 32'hDEADBEEF;
        localparam logic        MIS_ERR     = 1'b0;
        localparam logic [31:0] W4_AFTER    = 32'hDEADBEAB;
`endif

        //            s     we    addr          wdata         strb  exp_rdata     err   lat
        vecs.push_back('{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h20,  32'hAABBCCDD, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h20,  32'h11223344, 4'h5, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b0, 1'b0, 32'h20,  32'h0,        4'h0, 32'hAA22CC44, 1'b0, 3});
        vecs.push_back('{1'b0, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h0,   32'h12345678, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 3});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h12345678, 1'b0, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h40,  32'h55555555, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h40,  32'hCAFEF00D, 4'h0, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b0, 1'b0, 32'h40,  32'h0,        4'h0, 32'h55555555, 1'b0, 3});
        vecs.push_back('{1'b0, 1'b0, 32'h12,  32'h0,        4'h0, MIS_LD_DATA,  MIS_ERR, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h13,  32'h000000AB, 4'h1, 32'h0,        MIS_ERR, 3});
        vecs.push_back('{1'b0, 1'b0, 32'h10,  32'h0,        4'h0, W4_AFTER,     1'b0, 3});
        vecs.push_back('{1'b0, 1'b1, 32'h30,  32'h01020304, 4'hF, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b1, 1'b1, 32'h8,   32'hA5A5_5A5A, 4'hF, 32'h0,       1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 32'h8,   32'h0,        4'h0, 32'hA5A55A5A, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 32'h7FC, 32'h0,        4'h0, 32'h0,        1'b1, 1});

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready_a", 32'(ia.req_ready), 32'd1);
        chk("reset_rsp_valid_a", 32'(ia.rsp_valid), 32'd0);
        chk("reset_rsp_rdata_a", ia.rsp_rdata, 32'd0);
        chk("reset_rsp_err_a",   32'(ia.rsp_err), 32'd0);
        chk("reset_req_ready_b", 32'(ib.req_ready), 32'd1);
        chk("reset_rsp_valid_b", 32'(ib.rsp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            start_req(vecs[i].s, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), m_rsp_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(m_rsp_err), 32'(vecs[i].exp_err));
            finish_rsp();
        end

        // Response backpressure: hold rsp_ready low for 5 cycles with the response pending.
        start_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat);
        chk("bp_latency", 32'(lat), 32'd3);
        held = m_rsp_rdata;
        chk("bp_first_rdata", held, 32'hAA22CC44);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid_c%0d", c), 32'(m_rsp_valid), 32'd1);
            chk($sformatf("bp_rdata_c%0d", c), m_rsp_rdata, 32'hAA22CC44);
            chk($sformatf("bp_req_ready_c%0d", c), 32'(m_req_ready), 32'd0);
        end
        finish_rsp();
        chk("bp_release_valid", 32'(m_rsp_valid), 32'd0);
        chk("bp_release_req_ready", 32'(m_req_ready), 32'd1);
        chk("bp_release_rdata", m_rsp_rdata, 32'd0);

        // Async reset during WAIT of a store to 0x30 must abort it without writing.
        sel       = 1'b0;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'hFFFF_FFFF;
        req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_in_wait_req_ready", 32'(m_req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_req_ready", 32'(m_req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("abort_rsp_rdata", m_rsp_rdata, 32'd0);
        chk("abort_rsp_err",   32'(m_rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_req(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, lat);
        chk("abort_load_latency", 32'(lat), 32'd3);
        chk("abort_load_rdata", m_rsp_rdata, 32'h01020304);
        finish_rsp();

        // Committed store survives a later reset.
        start_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat);
        chk("post_reset_mem4", m_rsp_rdata, W4_AFTER);
        finish_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
